instruction_fetch: RTL and testbench

Fetch stage of the single-issue LEGv8-style datapath. Holds the program counter, issues word reads to instruction memory over a req/ready handshake, and presents each fetched word to the instruction decoder for one issue slot. It consumes the decoder's `ub`, `cb` and `imm` outputs plus the ALU `zero` flag to pick the next PC: sequential, unconditional branch, or CBZ-taken.

---
 rtl/instruction_fetch.sv | 137 +++++++++++++
 tb/tb_instruction_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, reads instruction memory over req/ready and issues one word per slot.
// Optional FETCH_HALT_EN macro adds a HALT state entered on the HLT word (32'hD440_0000).
`timescale 1ns/1ps
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ub,
    input  logic        i_cb,
    input  logic        i_zero,
    input  logic [31:0] i_imm,
    input  logic        i_stall,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_valid,
    output logic        o_halted
);

    localparam int unsigned XLEN = 32;
`ifdef FETCH_HALT_EN
    localparam logic [XLEN-1:0] HLT_WORD = 32'hD440_0000;
`endif

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
`ifdef FETCH_HALT_EN
        , ST_HALT = 2'd3
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instruction;
    logic            r_valid;
    logic            r_imem_req;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_instr_nxt;
    logic            w_valid_nxt;
    logic            w_req_nxt;
    logic            w_taken;
    logic [XLEN-1:0] w_pc_seq;
    logic [XLEN-1:0] w_pc_br;
`ifdef FETCH_HALT_EN
    logic            r_halted;
    logic            w_halted_nxt;
`endif

    // Branch target arithmetic; imm only matters on the taken leg of the mux
    assign w_taken  = i_ub | (i_cb & i_zero);
    assign w_pc_seq = r_pc + XLEN'(4);
    assign w_pc_br  = r_pc + {i_imm[XLEN-3:0], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_START;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_START: w_state_nxt = ST_FETCH;
            ST_FETCH: if (i_imem_ready) w_state_nxt = ST_ISSUE;
`ifdef FETCH_HALT_EN
            ST_ISSUE: if (!i_stall) w_state_nxt = (r_instruction == HLT_WORD) ? ST_HALT : ST_FETCH;
            ST_HALT:  w_state_nxt = ST_HALT;
`else
            ST_ISSUE: if (!i_stall) w_state_nxt = ST_FETCH;
`endif
            default:  w_state_nxt = ST_START;
        endcase
    end

    // Next values of the registered outputs; request tracks the state being entered
    always_comb begin
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instruction;
        w_valid_nxt = r_valid;
        w_req_nxt   = (w_state_nxt == ST_FETCH);
`ifdef FETCH_HALT_EN
        w_halted_nxt = (w_state_nxt == ST_HALT);
`endif
        case (r_state)
            ST_FETCH: begin
                if (i_imem_ready) begin
                    w_instr_nxt = i_imem_rdata;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!i_stall) begin
                    w_valid_nxt = 1'b0;
                    if (w_state_nxt == ST_FETCH) w_pc_nxt = w_taken ? w_pc_br : w_pc_seq;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_instruction <= '0;
            r_valid       <= 1'b0;
            r_imem_req    <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_instruction <= w_instr_nxt;
            r_valid       <= w_valid_nxt;
            r_imem_req    <= w_req_nxt;
        end
    end

`ifdef FETCH_HALT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_halted <= 1'b0;
        else     r_halted <= w_halted_nxt;
    end
    assign o_halted = r_halted;
`else
    assign o_halted = 1'b0;
`endif

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_pc;
    assign o_instruction = r_instruction;
    assign o_pc          = r_pc;
    assign o_valid       = r_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected fetch addresses are queued by the stimulus
// and a monitor checks every accepted fetch and the issue slot that follows it.
`timescale 1ns/1ps
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_ub = 1'b0, i_cb = 1'b0, i_zero = 1'b0, i_stall = 1'b0;
    logic [31:0] i_imm = 32'h0;
    logic        i_imem_ready = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        o_imem_req, o_valid, o_halted;
    logic [31:0] o_imem_addr, o_instruction, o_pc;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .i_ub(i_ub), .i_cb(i_cb), .i_zero(i_zero), .i_imm(i_imm),
        .i_stall(i_stall), .i_imem_ready(i_imem_ready), .i_imem_rdata(i_imem_rdata),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .o_instruction(o_instruction),
        .o_pc(o_pc), .o_valid(o_valid), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    int          errors = 0, checks = 0, cyc = 0;
    logic [31:0] q_addr[$];
    logic [63:0] q_issue[$];
    int          mem_delay = 0, wait_cnt = 0;
    bit          force_rdy = 0, hlt_on = 0;
    logic [31:0] br_at = 32'h10, br_imm = 32'h0;
    bit          br_ub = 0, br_cb = 0, br_zero = 0, stall_mode = 0;
    int          iss_cnt = 0;
    int          vcnt = 0, acc_first = -1, acc_last = 0, req_run = 0, last_req_run = 0, stall_seen = 0;
    bit          addr_moved = 0, pend = 0;
    logic [31:0] req_addr0 = 32'h0;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (hlt_on && a == 32'h20) return 32'hD440_0000;
        return 32'h8B00_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_empty(input int bound);
        int n = 0;
        while (q_addr.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(q_addr.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Memory and decoder model, driven just after each rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        i_imem_rdata = word(o_imem_addr);
        if (o_imem_req && q_addr.size() != 0) begin
            i_imem_ready = (wait_cnt >= mem_delay);
            wait_cnt++;
        end else begin
            i_imem_ready = 1'b0;
            if (!o_imem_req) wait_cnt = 0;
        end
        if (force_rdy) i_imem_ready = 1'b1;
        if (o_valid && o_pc == br_at) begin
            i_ub    = br_ub;
            i_cb    = br_cb;
            i_imm   = br_imm;
            i_zero  = stall_mode ? (iss_cnt % 2 == 0) : br_zero;
            i_stall = stall_mode && (iss_cnt < 3);
            iss_cnt++;
        end else begin
            i_ub    = 1'b0;
            i_cb    = 1'b0;
            i_imm   = 'x;
            i_zero  = 1'($urandom_range(1));
            i_stall = 1'b0;
            iss_cnt = 0;
        end
    end

    // Monitor: pops the scoreboard on every accepted fetch and checks the following issue slot
    initial forever begin
        logic [63:0] e;
        logic [31:0] ea;
        @(negedge clk);
        if (pend) begin
            pend = 0;
            e = q_issue.pop_front();
            chk("issue_valid", 32'(o_valid), 32'd1);
            chk("issue_pc", o_pc, e[63:32]);
            chk("issue_instr", o_instruction, e[31:0]);
        end
        if (o_valid) vcnt++;
        if (i_stall && o_valid) begin
            stall_seen++;
            chk("stall_pc", o_pc, 32'h10);
            chk("stall_instr", o_instruction, 32'h8B00_0010);
        end
        if (o_imem_req) begin
            if (req_run == 0) req_addr0 = o_imem_addr;
            else if (o_imem_addr !== req_addr0) addr_moved = 1;
            req_run++;
        end else begin
            req_run = 0;
        end
        if (o_imem_req && i_imem_ready && !rst) begin
            if (q_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got addr %h want none", o_imem_addr);
            end else begin
                ea = q_addr.pop_front();
                chk("fetch_addr", o_imem_addr, ea);
                q_issue.push_back({ea, word(ea)});
                pend = 1;
            end
            if (acc_first < 0) acc_first = cyc;
            acc_last     = cyc;
            last_req_run = req_run;
            req_run      = 0;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_addr", o_imem_addr, 32'h0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_instr", o_instruction, 32'h0);
        chk("rst_halted", 32'(o_halted), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back fetches with memory ready immediately
        vcnt = 0; acc_first = -1;
        q_addr.push_back(32'h0); q_addr.push_back(32'h4); q_addr.push_back(32'h8);
        wait_empty(100);
        repeat (2) @(negedge clk);
        chk("seq_valid_cycles", 32'(vcnt), 32'd3);
        chk("seq_accept_span", 32'(acc_last - acc_first), 32'd4);

        // Slow memory plus unconditional branch back from 0x10
        mem_delay = 3; br_ub = 1; br_imm = 32'hFFFF_FFFE; addr_moved = 0;
        q_addr.push_back(32'hC); q_addr.push_back(32'h10); q_addr.push_back(32'h08);
        wait_empty(200);
        chk("slow_req_cycles", 32'(last_req_run), 32'd4);
        chk("slow_addr_stable", 32'(addr_moved), 32'd0);

        // CBZ not taken
        mem_delay = 0; br_ub = 0; br_cb = 1; br_zero = 0; br_imm = 32'h5;
        q_addr.push_back(32'hC); q_addr.push_back(32'h10); q_addr.push_back(32'h14);
        wait_empty(100);

        // Reset with a request outstanding and a stray ready during reset and START
        @(negedge clk);
        chk("pre_rst_req", 32'(o_imem_req), 32'd1);
        chk("pre_rst_addr", o_imem_addr, 32'h18);
        force_rdy = 1; rst = 1'b1;
        #1;
        chk("async_rst_req", 32'(o_imem_req), 32'd0);
        chk("async_rst_pc", o_pc, 32'h0);
        chk("async_rst_valid", 32'(o_valid), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        force_rdy = 0; br_zero = 1;
        q_addr.push_back(32'h0); q_addr.push_back(32'h4); q_addr.push_back(32'h8);
        q_addr.push_back(32'hC); q_addr.push_back(32'h10); q_addr.push_back(32'h24);
        @(negedge clk);
        chk("start_ignores_ready_valid", 32'(o_valid), 32'd0);
        chk("start_ignores_ready_instr", o_instruction, 32'h0);
        chk("restart_req", 32'(o_imem_req), 32'd1);
        chk("restart_addr", o_imem_addr, 32'h0);
        wait_empty(100);

        // Stall for three cycles while zero toggles; only the final sample counts
        do_reset();
        stall_mode = 1; stall_seen = 0; br_cb = 1; br_imm = 32'h5;
        q_addr.push_back(32'h0); q_addr.push_back(32'h4); q_addr.push_back(32'h8);
        q_addr.push_back(32'hC); q_addr.push_back(32'h10); q_addr.push_back(32'h14);
        wait_empty(100);
        stall_mode = 0;
        chk("stall_cycles", 32'(stall_seen), 32'd3);

        // HLT word at 0x20
        do_reset();
        hlt_on = 1; br_cb = 0;
        for (int a = 0; a <= 32; a += 4) q_addr.push_back(32'(a));
`ifdef FETCH_HALT_EN
        begin
            int n = 0;
            while (!o_halted && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (3) @(negedge clk);
        chk("halt_halted", 32'(o_halted), 32'd1);
        chk("halt_req", 32'(o_imem_req), 32'd0);
        chk("halt_pc", o_pc, 32'h20);
        chk("halt_valid", 32'(o_valid), 32'd0);
        q_addr.delete();
`else
        q_addr.push_back(32'h24);
        wait_empty(200);
        chk("hlt_no_halt", 32'(o_halted), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
